// File: rtl/bcd_converter_if.sv
// Stream interface between the FIFO read side, the converter and the display stage.
// The master drives words in and observes results; the slave is the converter.
interface bcd_converter_if;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [19:0] bcd_out;
  logic [4:0]  digit_en;
  logic        parity_out;
  logic        busy;

  modport master (
    output in_valid, in_data,
    input  in_ready, out_valid, bcd_out, digit_en, parity_out, busy
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, out_valid, bcd_out, digit_en, parity_out, busy
  );
endinterface

// File: rtl/bcd_converter.sv
// Sequential 16-bit binary to 5-digit packed BCD converter (double-dabble, one shift per clock)
// with a leading-zero digit-enable mask and even parity of the accepted word.
module bcd_converter (
  input logic            clk,
  input logic            rst,
  bcd_converter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_r;
  logic [15:0] shift_r;
  logic [19:0] scratch_r;
  logic [3:0]  count_r;
  logic        parity_r;
  logic [19:0] bcd_r;
  logic [4:0]  digit_en_r;
  logic        parity_out_r;
  logic        out_valid_r;

  logic [19:0] adjusted_s;
  logic [35:0] shifted_s;

  function automatic logic [19:0] add3_digits(input logic [19:0] s);
    logic [19:0] r;
    r = s;
    for (int k = 0; k < 5; k++) begin
      if (s[4*k +: 4] >= 4'd5) begin
        r[4*k +: 4] = s[4*k +: 4] + 4'd3;
      end else begin
        r[4*k +: 4] = s[4*k +: 4];
      end
    end
    return r;
  endfunction

  function automatic logic even_parity16(input logic [15:0] w);
    return ^w;
  endfunction

  // Digit k is significant if it or any more significant digit is nonzero; the units digit always shows.
  function automatic logic [4:0] lead_mask(input logic [19:0] s);
    logic [4:0] m;
    logic       seen;
    seen = 1'b0;
    m    = 5'b00000;
    for (int k = 4; k >= 0; k--) begin
      seen = seen | (s[4*k +: 4] != 4'd0);
      m[k] = seen;
    end
    m[0] = 1'b1;
    return m;
  endfunction

  // One double-dabble iteration: per-digit add-3 correction, then a 36-bit left shift.
  always_comb begin
    adjusted_s = add3_digits(scratch_r);
    shifted_s  = {adjusted_s[18:0], shift_r, 1'b0};
  end

  // Conversion FSM with registered result outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r      <= IDLE;
      shift_r      <= 16'd0;
      scratch_r    <= 20'd0;
      count_r      <= 4'd0;
      parity_r     <= 1'b0;
      bcd_r        <= 20'd0;
      digit_en_r   <= 5'd0;
      parity_out_r <= 1'b0;
      out_valid_r  <= 1'b0;
    end else begin
      out_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.in_valid) begin
            shift_r   <= bus.in_data;
            scratch_r <= 20'd0;
            count_r   <= 4'd0;
            parity_r  <= even_parity16(bus.in_data);
            state_r   <= SHIFT;
          end else begin
            state_r <= IDLE;
          end
        end
        SHIFT: begin
          {scratch_r, shift_r} <= shifted_s;
          count_r              <= count_r + 4'd1;
          if (count_r == 4'd15) begin
            state_r <= DONE;
          end else begin
            state_r <= SHIFT;
          end
        end
        DONE: begin
          bcd_r        <= scratch_r;
          digit_en_r   <= lead_mask(scratch_r);
          parity_out_r <= parity_r;
          out_valid_r  <= 1'b1;
          state_r      <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready   = (state_r == IDLE);
  assign bus.busy       = (state_r != IDLE);
  assign bus.out_valid  = out_valid_r;
  assign bus.bcd_out    = bcd_r;
  assign bus.digit_en   = digit_en_r;
  assign bus.parity_out = parity_out_r;

endmodule

// File: tb/tb_bcd_converter.sv
// Directed self-checking bench for bcd_converter, plus a short random sweep
// compared against a decimal-arithmetic reference.
module tb_bcd_converter;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  int   cyc;
  int   accepts;
  int   pulses;

  bcd_converter_if bus ();

  bcd_converter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst && bus.in_valid && bus.in_ready) accepts <= accepts + 1;
    if (bus.out_valid) pulses <= pulses + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [19:0] ref_bcd(input logic [15:0] v);
    logic [19:0] r;
    int          x;
    x = int'(v);
    r = 20'd0;
    for (int k = 0; k < 5; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [4:0] ref_mask(input logic [15:0] v);
    logic [4:0] m;
    m = 5'b00001;
    if (v >= 16'd10)    m[1] = 1'b1;
    if (v >= 16'd100)   m[2] = 1'b1;
    if (v >= 16'd1000)  m[3] = 1'b1;
    if (v >= 16'd10000) m[4] = 1'b1;
    return m;
  endfunction

  task automatic run_word(input string tag, input logic [15:0] v, input logic [19:0] eb,
                          input logic [4:0] ee, input logic ep);
    int n;
    n = 0;
    while (!bus.in_ready && n < 40) begin step(); n++; end
    bus.in_valid = 1'b1;
    bus.in_data  = v;
    step();
    bus.in_valid = 1'b0;
    bus.in_data  = 16'd0;
    n = 0;
    while (!bus.out_valid && n < 40) begin step(); n++; end
    check({tag, ".latency"}, 32'(n), 32'd17);
    check({tag, ".bcd"}, 32'(bus.bcd_out), 32'(eb));
    check({tag, ".en"}, 32'(bus.digit_en), 32'(ee));
    check({tag, ".par"}, 32'(bus.parity_out), 32'(ep));
    step();
    check({tag, ".pulse_width"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    int          n;
    int          last;
    int          acc0;
    int          ov0;
    logic [15:0] v;

    n_checks = 0; n_errors = 0; cyc = 0; accepts = 0; pulses = 0;
    rst = 1'b0; bus.in_valid = 1'b0; bus.in_data = 16'd0;
    repeat (3) step();
    rst = 1'b1;
    check("rst.bcd", 32'(bus.bcd_out), 32'd0);
    check("rst.en", 32'(bus.digit_en), 32'd0);
    check("rst.par", 32'(bus.parity_out), 32'd0);
    check("rst.ov", 32'(bus.out_valid), 32'd0);
    check("rst.ready", 32'(bus.in_ready), 32'd1);
    check("rst.busy", 32'(bus.busy), 32'd0);

    run_word("zero", 16'd0, 20'h00000, 5'b00001, 1'b0);
    run_word("max", 16'd65535, 20'h65535, 5'b11111, 1'b0);
    run_word("1234", 16'd1234, 20'h01234, 5'b01111, 1'b1);
    run_word("10946", 16'd10946, 20'h10946, 5'b11111, 1'b0);
    run_word("9", 16'd9, 20'h00009, 5'b00001, 1'b0);
    run_word("10", 16'd10, 20'h00010, 5'b00011, 1'b0);
    run_word("10000", 16'd10000, 20'h10000, 5'b11111, 1'b1);

    // Back-to-back stream with in_valid held high; junk data while busy.
    last = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'd1;
    for (int k = 1; k <= 3; k++) begin
      step();
      bus.in_data = 16'd7777;
      n = 0;
      while (!bus.out_valid && n < 40) begin step(); n++; end
      check("stream.latency", 32'(n), 32'd17);
      check("stream.bcd", 32'(bus.bcd_out), 32'(k));
      check("stream.ready", 32'(bus.in_ready), 32'd1);
      if (k > 1) check("stream.spacing", 32'(cyc - last), 32'd18);
      last = cyc;
      bus.in_data = 16'(k + 1);
    end
    bus.in_valid = 1'b0;
    bus.in_data  = 16'd0;
    step();
    check("stream.pulse_width", 32'(bus.out_valid), 32'd0);

    // Abort a conversion with reset at edge N+8.
    bus.in_valid = 1'b1;
    bus.in_data  = 16'd9999;
    step();
    bus.in_valid = 1'b0;
    ov0 = pulses;
    repeat (7) step();
    check("abort.busy", 32'(bus.busy), 32'd1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    check("abort.ov", 32'(bus.out_valid), 32'd0);
    check("abort.bcd", 32'(bus.bcd_out), 32'd0);
    check("abort.en", 32'(bus.digit_en), 32'd0);
    check("abort.par", 32'(bus.parity_out), 32'd0);
    check("abort.ready", 32'(bus.in_ready), 32'd1);
    repeat (25) step();
    check("abort.no_pulse", 32'(pulses - ov0), 32'd0);
    run_word("42", 16'd42, 20'h00042, 5'b00011, 1'b1);

    // Reset asserted together with in_valid: nothing is accepted.
    rst = 1'b0; bus.in_valid = 1'b1; bus.in_data = 16'd5;
    step();
    rst = 1'b1; bus.in_valid = 1'b0;
    check("rstvalid.ready", 32'(bus.in_ready), 32'd1);

    // Random sweep against the decimal reference.
    acc0 = accepts;
    ov0  = pulses;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 3)) step();
      v = 16'($urandom);
      run_word("rand", v, ref_bcd(v), ref_mask(v), ^v);
    end
    check("rand.count", 32'(pulses - ov0), 32'(accepts - acc0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
